inst_mem_ctrl: RTL
==================

# inst_mem_ctrl

Controller that owns the single port of `inst_mem` and shares it between a boot/program loader and the core's fetch path. After reset it streams loader words into consecutive instruction addresses from 0 while holding the core stalled. On the last word it switches to run mode and passes fetch requests through with one-cycle read latency. It sits between the stack CPU's PC/fetch logic, the external program loader, and `inst_mem`.

## Interface
- `ABITS`, 32, width of PC, data and address buses
- `DEPTH`, 1024, instruction words in `inst_mem`; legal addresses are 0..DEPTH-1
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `ld_valid`  in  1  loader word present
- `ld_ready`  out  1  controller accepts a loader word this cycle
- `ld_data`  in  ABITS  loader instruction word
- `ld_last`  in  1  qualifies `ld_data` as the final word of the program
- `reload`  in  1  single-cycle request to re-enter load mode at address 0
- `fetch_req`  in  1  core requests an instruction
- `fetch_pc`  in  ABITS  fetch address
- `fetch_inst`  out  ABITS  fetched instruction; valid only when `fetch_valid` is high
- `fetch_valid`  out  1  `fetch_inst` holds the result of the previous cycle's fetch
- `cpu_stall`  out  1  core must hold its PC
- `load_count`  out  ABITS  words written in the current or most recent load
- `load_err`  out  1  program overflowed `DEPTH`
- `ld_csum`  out  ABITS  wrapping sum of loaded words (see Configuration)
- `mem_en`, `mem_we`  out  1  to `inst_mem` `en`/`we`
- `mem_pc`, `mem_din`  out  ABITS  to `inst_mem` `pc`/`din`
- `mem_dout`  in  ABITS  from `inst_mem` `dout`, registered, one cycle after `mem_en`

## Operation
- FSM has three states: LOAD, RUN and ERR. Reset enters LOAD.
- LOAD:
  - `ld_ready`=1 and `cpu_stall`=1; fetch inputs are ignored.
  - On `ld_valid & ld_ready`: `mem_en`=1, `mem_we`=1, `mem_pc`=addr, `mem_din`=`ld_data`, then addr+1 and `load_count`+1.
  - If `ld_last` is high on the accepted word, go to RUN.
  - If the accepted word is at addr DEPTH-1 and `ld_last` is low, go to ERR. That word is still written.
  - A last word at DEPTH-1 goes to RUN.
  - Cycles without an accepted word produce no memory access.
- RUN:
  - `ld_ready`=0 and `cpu_stall`=0.
  - `mem_en`=`fetch_req`, `mem_we`=0, `mem_pc`=`fetch_pc`, `mem_din`=0.
  - `fetch_valid` is set the cycle after an issued fetch.
  - A `fetch_pc` of DEPTH or more is still issued; the result is whatever `inst_mem` returns.
- ERR:
  - `load_err`=1, `ld_ready`=0, `cpu_stall`=1, no memory access.
  - Left only by `rst` or `reload`.
- `reload` (in RUN or ERR):
  - Next state is LOAD; addr, `load_count`, `ld_csum` and `load_err` clear to 0.
  - A fetch in the same cycle is not issued; `fetch_valid` is 0 in the following cycle.
  - `reload` in LOAD is ignored.
- Reset mid-load or mid-fetch: all state clears immediately, the FSM returns to LOAD at addr 0, and memory contents are not cleared.
- `mem_*` outputs are combinational from state and inputs. `ld_ready`, `cpu_stall` and `load_err` decode registered state only.
- Counter arithmetic is unsigned, ABITS wide. `ld_csum` wraps mod 2^ABITS.

## Timing
- Reset values:
  - state=LOAD, addr=0, `load_count`=0, `ld_csum`=0, `load_err`=0, `fetch_valid`=0.
  - `ld_ready`=1, `cpu_stall`=1.
  - `mem_en`=0, `mem_we`=0 while `ld_valid`=0.
- Load write takes effect at the clock edge where `ld_valid & ld_ready` is high. Throughput is one word per cycle.
- Last-word edge → RUN. `cpu_stall` and `ld_ready` drop in the next cycle; the first fetch can be issued that same cycle.
- Fetch latency is 1: request in cycle N, then `fetch_valid`=1 and `fetch_inst`=`mem_dout` in cycle N+1. Back-to-back fetches give one result per cycle.
- `fetch_inst` passes `mem_dout` straight through; no extra register.

## Configuration
- `IMEM_CTRL_CSUM_EN`
  - Defined: `ld_csum` accumulates each accepted `ld_data` at the write edge, clears on `rst`/`reload`, and holds in RUN/ERR.
  - Undefined: the accumulator is not built and `ld_csum` is tied to 0.

## Structure
- Shared package `inst_mem_ctrl_pkg`: FSM state enum (LOAD, RUN, ERR) and the default `ABITS`/`DEPTH` constants.
- One sub-module, `imem_ld_addr_cnt`: load address/count register with clear, increment and an at-top (DEPTH-1) flag.

## Test plan
- Reset, then load 3 words 0x11, 0x22, 0x33 with last on 0x33.
  - Addresses 0, 1, 2 are written; `load_count`=3.
  - RUN is entered the cycle after; `ld_csum`=0x66 with the macro, 0 without.
- In RUN, fetch pc 0, 1, 2 back-to-back → `fetch_valid` high for 3 cycles with 0x11, 0x22, 0x33, each one cycle after its request.
- Gapped loader (`ld_valid` toggling) → writes only on handshake cycles and `load_count` matches the accepted words.
- DEPTH=4, load 5 words with no last:
  - Addresses 0–3 are written; `load_err`=1 after the 4th.
  - The 5th is not accepted (`ld_ready`=0); `reload` returns to LOAD with `load_err`=0.
- `reload` asserted together with `fetch_req` in RUN → no `mem_en` that cycle, `fetch_valid`=0 next cycle, `cpu_stall`=1, new load starts at addr 0.
- `rst` asserted mid-load after 2 words → outputs at reset values immediately and the next load starts at address 0.

Source files
------------

// File: rtl/inst_mem_ctrl_pkg.sv
// Shared types and default sizes for the instruction memory controller.
package inst_mem_ctrl_pkg;

  localparam int DEF_ABITS = 32;
  localparam int DEF_DEPTH = 1024;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_ERR  = 2'd2
  } imem_state_t;

endpackage

// File: rtl/imem_ld_addr_cnt.sv
// Load address / word counter: the write address and the load count are the same value,
// cleared on reload and stepped once per accepted loader word.
module imem_ld_addr_cnt
  import inst_mem_ctrl_pkg::*;
#(
  parameter int ABITS = DEF_ABITS,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [ABITS-1:0] count,
  output logic             at_top
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + ABITS'(1);
    end
  end

  assign at_top = (count == ABITS'(DEPTH - 1));

endmodule

// File: rtl/inst_mem_ctrl.sv
// Shares the inst_mem port between the program loader (LOAD) and core fetch (RUN).
// Optional loaded-word checksum is built when IMEM_CTRL_CSUM_EN is defined.
module inst_mem_ctrl
  import inst_mem_ctrl_pkg::*;
#(
  parameter int ABITS = DEF_ABITS,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [ABITS-1:0] ld_data,
  input  logic             ld_last,
  input  logic             reload,
  input  logic             fetch_req,
  input  logic [ABITS-1:0] fetch_pc,
  output logic [ABITS-1:0] fetch_inst,
  output logic             fetch_valid,
  output logic             cpu_stall,
  output logic [ABITS-1:0] load_count,
  output logic             load_err,
  output logic [ABITS-1:0] ld_csum,
  output logic             mem_en,
  output logic             mem_we,
  output logic [ABITS-1:0] mem_pc,
  output logic [ABITS-1:0] mem_din,
  input  logic [ABITS-1:0] mem_dout
);

  // Loader handshake: a word transfers on any cycle where ld_valid & ld_ready are both high;
  // ld_ready depends only on registered state, never on ld_valid.
  imem_state_t      state, state_nxt;
  logic             accept;
  logic             issue;
  logic             clr;
  logic             at_top;
  logic [ABITS-1:0] addr;

  assign ld_ready  = (state == ST_LOAD);
  assign cpu_stall = (state != ST_RUN);
  assign load_err  = (state == ST_ERR);

  assign accept = ld_ready & ld_valid;
  assign issue  = (state == ST_RUN) & fetch_req & ~reload;
  assign clr    = (state != ST_LOAD) & reload;

  imem_ld_addr_cnt #(.ABITS(ABITS), .DEPTH(DEPTH)) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .inc    (accept),
    .count  (addr),
    .at_top (at_top)
  );

  assign load_count = addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_LOAD;
      fetch_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      fetch_valid <= issue;
    end
  end

  always_comb begin
    state_nxt = state;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_pc    = '0;
    mem_din   = '0;
    unique case (state)
      ST_LOAD: begin
        mem_en  = accept;
        mem_we  = accept;
        mem_pc  = addr;
        mem_din = accept ? ld_data : '0;
        // A last word at the top address still completes normally.
        if (accept) begin
          if (ld_last)     state_nxt = ST_RUN;
          else if (at_top) state_nxt = ST_ERR;
        end
      end
      ST_RUN: begin
        mem_en = issue;
        mem_pc = fetch_pc;
        if (reload) state_nxt = ST_LOAD;
      end
      ST_ERR: begin
        if (reload) state_nxt = ST_LOAD;
      end
      default: state_nxt = ST_LOAD;
    endcase
  end

  assign fetch_inst = mem_dout;

`ifdef IMEM_CTRL_CSUM_EN
  logic [ABITS-1:0] csum_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum_q <= '0;
    end else if (clr) begin
      csum_q <= '0;
    end else if (accept) begin
      csum_q <= csum_q + ld_data;
    end
  end

  assign ld_csum = csum_q;
`else
  assign ld_csum = '0;
`endif

endmodule
